// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, scan code constants and decode helpers
// Contents:
//   flags_t      controller error flags for a received byte; any bit set = bad byte
//   key_event_t  decoded key event {brk, ext, code}
//   dec_state_t  scan code set 2 prefix decoder states
//   is_sys_reply keyboard system reply bytes, which never become key events
//   mk_event     key event constructor
package ps2_pkg;

    typedef struct packed {
        logic timeout;
        logic frame_err;
        logic parity_err;
    } flags_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_event_t;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE    = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } dec_state_t;

    // 00 and FF are the key-detection-error / buffer-overrun replies.
    function automatic logic is_sys_reply(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_BAT_FAIL) || (b == PS2_ACK) ||
               (b == PS2_RESEND) || (b == PS2_ECHO) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic key_event_t mk_event(input logic is_brk, input logic is_ext,
                                            input logic [7:0] scan);
        return key_event_t'({is_brk, is_ext, scan});
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - generic first-word fall-through synchronous FIFO
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data; ignored when full unless pop happens in the same cycle
//   push_data    entry to write
//   pop          remove head entry; ignored when empty
//   pop_data     head entry, zero when empty
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
module ps2_event_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign do_pop   = pop & ~empty;
    // A simultaneous pop frees the head slot, so a full FIFO can still take a push.
    assign do_push  = push & (~full | do_pop);
    // Head is forced to zero when empty so stale storage never shows downstream.
    assign pop_data = empty ? T'('0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// rtl/ps2_kbd_decoder.sv - PS/2 scan code set 2 decoder with buffered key events
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rx_valid      controller byte valid; only its rising edge accepts a byte
//   rx_data       received byte
//   rx_flags      controller error flags; nonzero marks the byte bad
//   tx_pending    host transmit outstanding; masks rx_valid edges
//   rx_en         controller enable, low when the event FIFO is nearly full
//   ev_valid      key event available at FIFO head
//   ev_ready      consumer accepts the head event
//   ev_data       head event {brk, ext, code}
//   ctrl_valid    1-cycle strobe for a keyboard system reply
//   ctrl_code     last system reply byte
//   err           1-cycle strobe for a bad byte
//   ev_drop       1-cycle strobe for an event lost to a full FIFO
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  flags_t      rx_flags,
    input  logic        tx_pending,
    output logic        rx_en,
    output logic        ev_valid,
    input  logic        ev_ready,
    output key_event_t  ev_data,
    output logic        ctrl_valid,
    output logic [7:0]  ctrl_code,
    output logic        err,
    output logic        ev_drop
);

    localparam int CW = $clog2(DEPTH) + 1;

    dec_state_t     state_q;
    dec_state_t     state_d;
    logic [2:0]     pause_cnt_q;
    logic [2:0]     pause_cnt_d;
    logic           rx_valid_q;
    logic           accept;
    logic           good;
    logic           bad;
    logic           push;
    key_event_t     push_ev;
    logic           ctrl_hit;
    logic           pop;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;

    // The edge register tracks rx_valid even while tx_pending masks it, so the
    // tx-completion valid cannot be mistaken for a received byte afterwards.
    assign accept   = rx_valid & ~rx_valid_q & ~tx_pending;
    assign bad      = accept & (rx_flags != flags_t'('0));
    assign good     = accept & (rx_flags == flags_t'('0));
    assign ev_valid = ~empty;
    assign pop      = ev_valid & ev_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pause_cnt_q <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            rx_valid_q  <= rx_valid;
        end
    end

    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        push        = 1'b0;
        push_ev     = key_event_t'('0);
        ctrl_hit    = 1'b0;
        if (bad) begin
            state_d     = IDLE;
            pause_cnt_d = '0;
        end else if (good) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == PS2_EXT) begin
                        state_d = EXT;
                    end else if (rx_data == PS2_BRK) begin
                        state_d = BRK;
                    end else if (rx_data == PS2_PAUSE) begin
                        state_d     = PAUSE;
                        pause_cnt_d = 3'd7;
                    end else if (is_sys_reply(rx_data)) begin
                        ctrl_hit = 1'b1;
                    end else begin
                        push    = 1'b1;
                        push_ev = mk_event(1'b0, 1'b0, rx_data);
                    end
                end
                EXT: begin
                    if (rx_data == PS2_BRK) begin
                        state_d = EXT_BRK;
                    end else if (rx_data != PS2_EXT) begin
                        push    = 1'b1;
                        push_ev = mk_event(1'b0, 1'b1, rx_data);
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    push    = 1'b1;
                    push_ev = mk_event(1'b1, 1'b0, rx_data);
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    push    = 1'b1;
                    push_ev = mk_event(1'b1, 1'b1, rx_data);
                    state_d = IDLE;
                end
                PAUSE: begin
                    // Pause has no break code: the 7 bytes after E1 collapse into one event.
                    pause_cnt_d = pause_cnt_q - 3'd1;
                    if (pause_cnt_q == 3'd1) begin
                        push    = 1'b1;
                        push_ev = mk_event(1'b0, 1'b1, 8'h77);
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    pause_cnt_d = '0;
                end
            endcase
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .T     (key_event_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_ev),
        .pop       (pop),
        .pop_data  (ev_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // rx_en drops with one free slot left, so a byte already on the wire when
    // the bus is inhibited still has room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_en      <= 1'b1;
            ctrl_valid <= 1'b0;
            ctrl_code  <= '0;
            err        <= 1'b0;
            ev_drop    <= 1'b0;
        end else begin
            rx_en      <= (count <= CW'(DEPTH - 2));
            ctrl_valid <= ctrl_hit;
            if (ctrl_hit) begin
                ctrl_code <= rx_data;
            end
            err        <= bad;
            ev_drop    <= push & full & ~pop;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb/tb_ps2_kbd_decoder.sv - self-checking bench for ps2_kbd_decoder
module tb_ps2_kbd_decoder;
    import ps2_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    flags_t      rx_flags;
    logic        tx_pending;
    logic        rx_en;
    logic        ev_valid;
    logic        ev_ready;
    key_event_t  ev_data;
    logic        ctrl_valid;
    logic [7:0]  ctrl_code;
    logic        err;
    logic        ev_drop;

    ps2_kbd_decoder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_flags   (rx_flags),
        .tx_pending (tx_pending),
        .rx_en      (rx_en),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data),
        .ctrl_valid (ctrl_valid),
        .ctrl_code  (ctrl_code),
        .err        (err),
        .ev_drop    (ev_drop)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state: the pending prefix bytes of the current key sequence.
    logic [7:0] pref [$];
    logic [9:0] exp_ev [$];
    logic [7:0] exp_ctrl [$];
    int         exp_err  = 0;
    int         exp_drop = 0;

    // Observed DUT activity, collected on the falling edge.
    logic [9:0] got_ev [$];
    logic [7:0] got_ctrl [$];
    int         got_err  = 0;
    int         got_drop = 0;
    int         stab_viol = 0;
    logic       prev_hold = 1'b0;
    logic [9:0] prev_data = '0;
    bit         rand_ready = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && ev_valid && (ev_data !== prev_data)) stab_viol++;
            if (ev_valid && ev_ready) got_ev.push_back(ev_data);
            if (ctrl_valid) got_ctrl.push_back(ctrl_code);
            if (err) got_err++;
            if (ev_drop) got_drop++;
            prev_hold <= ev_valid & ~ev_ready;
            prev_data <= ev_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit pref_has(input logic [7:0] b);
        foreach (pref[i]) if (pref[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic emit(input logic brk, input logic ext, input logic [7:0] code);
        if (!ev_ready && (exp_ev.size() - got_ev.size() >= DEPTH)) exp_drop++;
        else exp_ev.push_back({brk, ext, code});
    endtask

    // Decode by looking at the set of prefixes seen since the last event.
    task automatic model_byte(input logic [7:0] b, input bit bad);
        bit has_brk;
        bit has_ext;
        if (bad) begin
            pref.delete();
            exp_err++;
            return;
        end
        if (pref.size() > 0 && pref[0] == 8'hE1) begin
            pref.push_back(b);
            if (pref.size() == 8) begin
                emit(1'b0, 1'b1, 8'h77);
                pref.delete();
            end
            return;
        end
        has_brk = pref_has(8'hF0);
        has_ext = pref_has(8'hE0);
        if (pref.size() == 0 && b == 8'hE1) pref.push_back(b);
        else if (pref.size() == 0 && (b inside {8'hAA, 8'hFC, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}))
            exp_ctrl.push_back(b);
        else if (!has_brk && (b == 8'hE0 || b == 8'hF0)) pref.push_back(b);
        else begin
            emit(has_brk, has_ext, b);
            pref.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ev_ready = $urandom_range(0, 1);
    endtask

    task automatic send(input logic [7:0] b, input bit bad, input bit force_send);
        int w = 0;
        if (!force_send) begin
            while (!rx_en && w < 200) begin
                tick();
                w++;
            end
            if (w >= 200) chk("rx_en wait timeout", 32'(w), 32'd0);
        end
        rx_data  = b;
        rx_flags = bad ? flags_t'(3'($urandom_range(1, 7))) : flags_t'('0);
        rx_valid = 1'b1;
        if (!tx_pending) model_byte(b, bad);
        repeat ($urandom_range(1, 3)) tick();
        rx_valid = 1'b0;
        rx_flags = flags_t'('0);
        repeat ($urandom_range(2, 4)) tick();
    endtask

    task automatic drain(input string tag);
        int w = 0;
        int n;
        rand_ready = 1'b0;
        ev_ready   = 1'b1;
        while (ev_valid && w < 100) begin
            tick();
            w++;
        end
        repeat (2) tick();
        chk({tag, " drain timeout"}, 32'(w < 100), 32'd1);
        chk({tag, " event count"}, 32'(got_ev.size()), 32'(exp_ev.size()));
        n = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s event %0d", tag, i), 32'(got_ev[i]), 32'(exp_ev[i]));
        chk({tag, " ctrl count"}, 32'(got_ctrl.size()), 32'(exp_ctrl.size()));
        n = (got_ctrl.size() < exp_ctrl.size()) ? got_ctrl.size() : exp_ctrl.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s ctrl %0d", tag, i), 32'(got_ctrl[i]), 32'(exp_ctrl[i]));
        chk({tag, " err count"}, 32'(got_err), 32'(exp_err));
        chk({tag, " drop count"}, 32'(got_drop), 32'(exp_drop));
        chk({tag, " ev_data stability"}, 32'(stab_viol), 32'd0);
        got_ev.delete();
        exp_ev.delete();
        got_ctrl.delete();
        exp_ctrl.delete();
        got_err  = 0;
        exp_err  = 0;
        got_drop = 0;
        exp_drop = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " rx_en"}, 32'(rx_en), 32'd1);
        chk({tag, " ev_valid"}, 32'(ev_valid), 32'd0);
        chk({tag, " ev_data"}, 32'(ev_data), 32'd0);
        chk({tag, " ctrl_valid"}, 32'(ctrl_valid), 32'd0);
        chk({tag, " ctrl_code"}, 32'(ctrl_code), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " ev_drop"}, 32'(ev_drop), 32'd0);
    endtask

    logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h21, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA,
                              8'hFE, 8'hEE, 8'h00, 8'hFF, 8'h74, 8'h77, 8'h14, 8'hE0};

    initial begin
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        rx_flags   = flags_t'('0);
        tx_pending = 1'b0;
        ev_ready   = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Plain make / break.
        send(8'h1C, 0, 0); send(8'hF0, 0, 0); send(8'h1C, 0, 0);
        drain("t1");
        // Extended keys, including a repeated E0.
        send(8'hE0, 0, 0); send(8'h75, 0, 0);
        send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
        send(8'hE0, 0, 0); send(8'hE0, 0, 0); send(8'h74, 0, 0);
        drain("t2");
        // Pause sequence then a plain key proves the FSM is back in IDLE.
        foreach (pool[i]) if (i < 0) send(pool[i], 0, 0);
        send(8'hE1, 0, 0); send(8'h14, 0, 0); send(8'h77, 0, 0); send(8'hE1, 0, 0);
        send(8'hF0, 0, 0); send(8'h14, 0, 0); send(8'hF0, 0, 0); send(8'h77, 0, 0);
        send(8'h1C, 0, 0);
        drain("t3");
        // Bad byte drops a pending E0 prefix.
        send(8'hE0, 0, 0); send(8'h55, 1, 0); send(8'h1C, 0, 0);
        drain("t4");
        // System replies.
        send(8'hAA, 0, 0); send(8'hFA, 0, 0);
        drain("t5");
        // tx_pending masks the edge; a later byte is still decoded.
        tx_pending = 1'b1;
        send(8'h1C, 0, 0);
        tx_pending = 1'b0;
        send(8'h32, 0, 0);
        drain("tx_pending");

        // Backpressure: rx_en throttling, absorb in-flight byte, drop when full.
        ev_ready = 1'b0;
        send(8'h1C, 0, 0); send(8'h32, 0, 0); send(8'h21, 0, 0);
        repeat (3) tick();
        chk("t6 rx_en at count 3", 32'(rx_en), 32'(exp_ev.size() <= DEPTH - 2));
        chk("t6 ev_valid held", 32'(ev_valid), 32'd1);
        chk("t6 head held", 32'(ev_data), 32'(exp_ev[0]));
        send(8'h23, 0, 1);
        repeat (3) tick();
        chk("t6 rx_en at full", 32'(rx_en), 32'd0);
        send(8'h2B, 0, 1);
        drain("t6");
        chk("t6 rx_en after drain", 32'(rx_en), 32'd1);

        // Random byte stream with random backpressure and occasional bad bytes.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++)
            send(pool[$urandom_range(0, 15)], ($urandom_range(0, 15) == 0), 0);
        drain("random");

        // Reset in the middle of an E0 prefix.
        send(8'hE0, 0, 0);
        rst_n = 1'b0;
        #3;
        check_reset_outputs("mid reset");
        pref.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send(8'h1C, 0, 0);
        drain("t7");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
